spi_burst_seq: RTL and testbench

Register-access sequencer sitting directly upstream of the 8-bit SPI master byte engine. It turns one read or write request into a framed multi-byte SPI transaction. It holds its own chip select low across all bytes, because the master deasserts its select between bytes. It drives the master's start/data_in handshake, collects returned bytes into a packed frame, and flags completion or timeout to the IMU/flight-control logic.

---
 rtl/spi_burst_seq_pkg.sv | 26 ++
 rtl/spi_burst_seq_if.sv | 27 ++
 rtl/spi_burst_seq.sv | 167 ++++++++++++++++
 tb/tb_spi_burst_seq.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_burst_seq_pkg.sv
// Shared types and constants for the SPI register-burst sequencer.
// Holds the FSM encoding, the command-byte read flag, the dummy byte and a constant clog2.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD
    } seq_state_t;

    localparam logic       SPI_RD_BIT = 1'b1;
    localparam logic [7:0] SPI_DUMMY  = 8'h00;

    // Never returns less than 1, so a width derived from it is always legal.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_burst_seq_if.sv
// Byte-engine link between the burst sequencer (master) and the 8-bit SPI byte engine (slave).
// The sequencer drives start/data_in and watches busy/new_data/data_out.
interface spi_burst_seq_if;

    logic       spi_start;
    logic [7:0] spi_data_in;
    logic       spi_busy;
    logic       spi_new_data;
    logic [7:0] spi_data_out;

    modport master (
        output spi_start,
        output spi_data_in,
        input  spi_busy,
        input  spi_new_data,
        input  spi_data_out
    );

    modport slave (
        input  spi_start,
        input  spi_data_in,
        output spi_busy,
        output spi_new_data,
        output spi_data_out
    );

endinterface

// File: rtl/spi_burst_seq.sv
// Frames one register read burst or single write as a multi-byte SPI transaction under a held cs_n.
// Latency: first spi_start 1+CS_SETUP_CYC cycles after start; backpressure: waits on spi_busy, drops start while busy.
module spi_burst_seq
    import spi_pkg::*;
#(
    parameter int NUM_REGS     = 6,
    parameter int CS_SETUP_CYC = 4,
    parameter int CS_HOLD_CYC  = 4,
    parameter int TIMEOUT_CYC  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  wr,
    input  logic [6:0]            addr,
    input  logic [7:0]            wr_data,
    output logic                  busy,
    output logic [8*NUM_REGS-1:0] frame_data,
    output logic                  frame_valid,
    output logic                  wr_done,
    output logic                  timeout,
    output logic                  cs_n,
    spi_burst_seq_if.master       spi
);

    localparam int FRAME_W = 8 * NUM_REGS;
    localparam int WD_W    = clog2(TIMEOUT_CYC);
    localparam int SU_W    = clog2(CS_SETUP_CYC);
    localparam int HO_W    = clog2(CS_HOLD_CYC);
    localparam int CNT_W   = (WD_W >= SU_W && WD_W >= HO_W) ? WD_W :
                             ((SU_W >= HO_W) ? SU_W : HO_W);
    localparam int IDX_W   = clog2(NUM_REGS + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(CS_SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(CS_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] WD_LAST     = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] RD_LAST_IDX = IDX_W'(NUM_REGS);
    localparam logic [IDX_W-1:0] WR_LAST_IDX = IDX_W'(1);

    seq_state_t         state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt, last_idx;
    logic               req_wr;
    logic [6:0]         req_addr;
    logic [7:0]         req_wdata;
    logic [FRAME_W-1:0] shift, shift_nxt;
    logic               issue_req;
    logic               spi_start_nxt;
    logic [7:0]         spi_data_nxt;
    logic               frame_valid_nxt, wr_done_nxt, timeout_nxt;

    assign last_idx = req_wr ? WR_LAST_IDX : RD_LAST_IDX;

    function automatic logic [7:0] tx_byte(input logic [IDX_W-1:0] i, input logic w,
                                           input logic [6:0] a, input logic [7:0] d);
        if (i == '0) return {(w ? ~SPI_RD_BIT : SPI_RD_BIT), a};
        return w ? d : SPI_DUMMY;
    endfunction

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        idx_nxt         = idx;
        shift_nxt       = shift;
        issue_req       = 1'b0;
        spi_start_nxt   = 1'b0;
        spi_data_nxt    = spi.spi_data_in;
        frame_valid_nxt = 1'b0;
        wr_done_nxt     = 1'b0;
        timeout_nxt     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_SETUP;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                end
            end
            ST_SETUP: begin
                if (cnt == SETUP_LAST) issue_req = 1'b1;
                else                   cnt_nxt   = cnt + CNT_W'(1);
            end
            ST_ISSUE: issue_req = 1'b1;
            ST_WAIT: begin
                if (spi.spi_new_data) begin
                    // Byte 0 answers the command byte and carries no register data.
                    if (idx != '0 && !req_wr)
                        shift_nxt = (shift << 8) | FRAME_W'(spi.spi_data_out);
                    if (idx == last_idx) begin
                        state_nxt = ST_HOLD;
                        cnt_nxt   = '0;
                    end else begin
                        idx_nxt   = idx + IDX_W'(1);
                        issue_req = 1'b1;
                    end
                end else if (cnt == WD_LAST) begin
                    state_nxt   = ST_IDLE;
                    timeout_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_nxt       = ST_IDLE;
                    frame_valid_nxt = !req_wr;
                    wr_done_nxt     = req_wr;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Fire straight from the deciding cycle so no extra cycle is lost when the engine is free.
        if (issue_req) begin
            if (!spi.spi_busy) begin
                spi_start_nxt = 1'b1;
                spi_data_nxt  = tx_byte(idx_nxt, req_wr, req_addr, req_wdata);
                cnt_nxt       = '0;
                state_nxt     = ST_WAIT;
            end else begin
                state_nxt = ST_ISSUE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            idx             <= '0;
            shift           <= '0;
            req_wr          <= 1'b0;
            req_addr        <= '0;
            req_wdata       <= '0;
            spi.spi_start   <= 1'b0;
            spi.spi_data_in <= '0;
            busy            <= 1'b0;
            cs_n            <= 1'b1;
            frame_data      <= '0;
            frame_valid     <= 1'b0;
            wr_done         <= 1'b0;
            timeout         <= 1'b0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            idx             <= idx_nxt;
            shift           <= shift_nxt;
            if (state == ST_IDLE && start) begin
                req_wr    <= wr;
                req_addr  <= addr;
                req_wdata <= wr_data;
            end
            spi.spi_start   <= spi_start_nxt;
            spi.spi_data_in <= spi_data_nxt;
            busy            <= (state_nxt != ST_IDLE);
            cs_n            <= (state_nxt == ST_IDLE);
            if (frame_valid_nxt) frame_data <= shift;
            frame_valid     <= frame_valid_nxt;
            wr_done         <= wr_done_nxt;
            timeout         <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_spi_burst_seq.sv
// Directed bench for spi_burst_seq with a behavioural byte-engine model and a negedge monitor.
// Covers reset, burst read, write, cs timing, timeout, ignored start, async reset and back-to-back frames.
module tb_spi_burst_seq;

    localparam int NR  = 6;
    localparam int LAT = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          wr = 1'b0;
    logic [6:0]    addr = '0;
    logic [7:0]    wr_data = '0;
    logic          busy, frame_valid, wr_done, timeout, cs_n;
    logic [8*NR-1:0] frame_data;

    spi_burst_seq_if sif();

    spi_burst_seq #(
        .NUM_REGS(NR), .CS_SETUP_CYC(4), .CS_HOLD_CYC(4), .TIMEOUT_CYC(64)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .wr(wr), .addr(addr), .wr_data(wr_data),
        .busy(busy), .frame_data(frame_data), .frame_valid(frame_valid), .wr_done(wr_done),
        .timeout(timeout), .cs_n(cs_n), .spi(sif)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int gap = 0;
    int drop_idx = -1;
    int resp_mul = 17;

    int         start_log[$];
    logic [7:0] mosi_log[$];
    int         nd_log[$];
    int         fv_total = 0, wd_total = 0, to_total = 0;
    int         last_done_cyc = 0, last_cs_rise = 0, cs_viol = 0;
    logic       to_cs_n = 1'b0, to_busy = 1'b1, cs_prev = 1'b1;

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    // Byte engine: busy for LAT cycles per byte, then new_data; optional busy gap models the ss gap.
    initial begin
        int rem, grem, bidx;
        rem = 0; grem = 0; bidx = 0;
        sif.spi_busy = 1'b0; sif.spi_new_data = 1'b0; sif.spi_data_out = '0;
        forever begin
            @(posedge clk); #1;
            sif.spi_new_data = 1'b0;
            if (rst) begin
                sif.spi_busy = 1'b0; rem = 0; grem = 0; bidx = 0;
            end else begin
                if (cs_n) bidx = 0;
                if (grem > 0) begin
                    grem--;
                    if (grem == 0) sif.spi_busy = 1'b0;
                end else if (sif.spi_start) begin
                    sif.spi_busy = 1'b1; rem = LAT;
                end else if (rem > 0) begin
                    rem--;
                    if (rem == 0) begin
                        if (bidx != drop_idx) begin
                            sif.spi_new_data = 1'b1;
                            sif.spi_data_out = (bidx == 0) ? 8'hEE : 8'(resp_mul * bidx);
                        end
                        bidx++;
                        if (gap > 0) grem = gap;
                        else         sif.spi_busy = 1'b0;
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (sif.spi_start) begin start_log.push_back(cyc); mosi_log.push_back(sif.spi_data_in); end
        if (sif.spi_new_data) nd_log.push_back(cyc);
        if (frame_valid) begin fv_total++; last_done_cyc = cyc; end
        if (wr_done) begin wd_total++; last_done_cyc = cyc; end
        if (timeout) begin to_total++; last_done_cyc = cyc; to_cs_n = cs_n; to_busy = busy; end
        if (cs_n && !cs_prev) last_cs_rise = cyc;
        if (cs_n && (busy || sif.spi_busy || sif.spi_start)) cs_viol++;
        cs_prev = cs_n;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "global timeout");
    end

    task automatic do_req(input logic w, input logic [6:0] a, input logic [7:0] d, output int c);
        @(posedge clk); #1;
        wr = w; addr = a; wr_data = d; start = 1'b1; c = cyc;
        @(posedge clk); #1;
        start = 1'b0; wr = 1'b0;
    endtask

    task automatic wait_done(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clk); #1;
            if (frame_valid || wr_done || timeout) ok = 1'b1;
        end
    endtask

    task automatic wait_starts(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk); #1;
            if (start_log.size() >= n) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++; if (cs_n !== 1'b1) begin bad++; $display("FAIL rst_cs_n got=%b want=1", cs_n); end
        total++; if (sif.spi_start !== 1'b0) begin bad++; $display("FAIL rst_spi_start got=%b want=0", sif.spi_start); end
        total++; if (sif.spi_data_in !== 8'h00) begin bad++; $display("FAIL rst_spi_data_in got=%h want=00", sif.spi_data_in); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (frame_data !== '0) begin bad++; $display("FAIL rst_frame_data got=%h want=0", frame_data); end
        total++; if ({frame_valid, wr_done, timeout} !== 3'b000) begin bad++; $display("FAIL rst_pulses got=%b want=000", {frame_valid, wr_done, timeout}); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++; if ({cs_n, busy} !== 2'b10) begin bad++; $display("FAIL idle_after_rst cs_n/busy got=%b want=10", {cs_n, busy}); end
    endtask

    task automatic test_burst_read;
        int c, sb, nb, fv0, wd0, to0, cv0;
        bit ok;
        logic [7:0] exp;
        logic [8*NR-1:0] exp_frame;
        gap = 0; drop_idx = -1; resp_mul = 17;
        sb = start_log.size(); nb = nd_log.size();
        fv0 = fv_total; wd0 = wd_total; to0 = to_total; cv0 = cs_viol;
        do_req(1'b0, 7'h3B, 8'h00, c);
        wait_done(400, ok);
        total++; if (!ok) begin bad++; $display("FAIL rd_done_wait got=none want=pulse within 400 cycles"); end
        total++; if ({cs_n, busy} !== 2'b10) begin bad++; $display("FAIL rd_end_cs_busy got=%b want=10", {cs_n, busy}); end
        total++; if (start_log.size() - sb !== 7) begin bad++; $display("FAIL rd_byte_count got=%0d want=7", start_log.size() - sb); end
        if (start_log.size() - sb >= 7 && nd_log.size() - nb >= 7) begin
            for (int i = 0; i < 7; i++) begin
                exp = (i == 0) ? 8'hBB : 8'h00;
                total++; if (mosi_log[sb+i] !== exp) begin bad++; $display("FAIL rd_mosi[%0d] got=%h want=%h", i, mosi_log[sb+i], exp); end
            end
            for (int i = 1; i < 7; i++) begin
                total++; if (start_log[sb+i] - nd_log[nb+i-1] !== 1) begin bad++; $display("FAIL rd_issue_gap[%0d] got=%0d want=1", i, start_log[sb+i] - nd_log[nb+i-1]); end
            end
            total++; if (start_log[sb] - c !== 5) begin bad++; $display("FAIL cs_setup got=%0d want=5", start_log[sb] - c); end
            total++; if (last_cs_rise - nd_log[nb+6] !== 5) begin bad++; $display("FAIL cs_hold got=%0d want=5", last_cs_rise - nd_log[nb+6]); end
        end
        total++; if (last_done_cyc !== last_cs_rise) begin bad++; $display("FAIL rd_fv_vs_cs got=%0d want=%0d", last_done_cyc, last_cs_rise); end
        exp_frame = 48'h112233445566;
        total++; if (frame_data !== exp_frame) begin bad++; $display("FAIL rd_frame got=%h want=%h", frame_data, exp_frame); end
        total++; if (fv_total - fv0 !== 1) begin bad++; $display("FAIL rd_fv_count got=%0d want=1", fv_total - fv0); end
        total++; if ((wd_total - wd0) + (to_total - to0) !== 0) begin bad++; $display("FAIL rd_other_pulses got=%0d want=0", (wd_total - wd0) + (to_total - to0)); end
        total++; if (cs_viol - cv0 !== 0) begin bad++; $display("FAIL rd_cs_high_in_frame got=%0d want=0", cs_viol - cv0); end
    endtask

    task automatic test_write;
        int c, sb, nb, fv0, wd0, cv0;
        bit ok;
        logic [8*NR-1:0] exp_frame;
        gap = 2;
        sb = start_log.size(); nb = nd_log.size();
        fv0 = fv_total; wd0 = wd_total; cv0 = cs_viol;
        do_req(1'b1, 7'h6B, 8'h01, c);
        wait_done(300, ok);
        total++; if (!ok) begin bad++; $display("FAIL wr_done_wait got=none want=pulse within 300 cycles"); end
        total++; if (start_log.size() - sb !== 2) begin bad++; $display("FAIL wr_byte_count got=%0d want=2", start_log.size() - sb); end
        if (start_log.size() - sb >= 2 && nd_log.size() - nb >= 2) begin
            total++; if (mosi_log[sb] !== 8'h6B) begin bad++; $display("FAIL wr_mosi0 got=%h want=6b", mosi_log[sb]); end
            total++; if (mosi_log[sb+1] !== 8'h01) begin bad++; $display("FAIL wr_mosi1 got=%h want=01", mosi_log[sb+1]); end
            total++; if (start_log[sb+1] - nd_log[nb] !== 3) begin bad++; $display("FAIL wr_busy_stall got=%0d want=3", start_log[sb+1] - nd_log[nb]); end
            total++; if (last_cs_rise - nd_log[nb+1] !== 5) begin bad++; $display("FAIL wr_cs_hold got=%0d want=5", last_cs_rise - nd_log[nb+1]); end
        end
        total++; if (wd_total - wd0 !== 1) begin bad++; $display("FAIL wr_done_count got=%0d want=1", wd_total - wd0); end
        total++; if (fv_total - fv0 !== 0) begin bad++; $display("FAIL wr_fv_count got=%0d want=0", fv_total - fv0); end
        exp_frame = 48'h112233445566;
        total++; if (frame_data !== exp_frame) begin bad++; $display("FAIL wr_frame_kept got=%h want=%h", frame_data, exp_frame); end
        total++; if (cs_viol - cv0 !== 0) begin bad++; $display("FAIL wr_cs_high_in_frame got=%0d want=0", cs_viol - cv0); end
        gap = 0;
    endtask

    task automatic test_timeout;
        int c, sb, fv0, to0;
        bit ok;
        logic [8*NR-1:0] exp_frame;
        drop_idx = 3; resp_mul = 17;
        sb = start_log.size(); fv0 = fv_total; to0 = to_total;
        do_req(1'b0, 7'h3B, 8'h00, c);
        wait_done(600, ok);
        total++; if (!ok) begin bad++; $display("FAIL to_wait got=none want=pulse within 600 cycles"); end
        total++; if (to_total - to0 !== 1) begin bad++; $display("FAIL to_count got=%0d want=1", to_total - to0); end
        total++; if (fv_total - fv0 !== 0) begin bad++; $display("FAIL to_fv_count got=%0d want=0", fv_total - fv0); end
        total++; if (start_log.size() - sb !== 4) begin bad++; $display("FAIL to_byte_count got=%0d want=4", start_log.size() - sb); end
        if (start_log.size() - sb >= 4) begin
            total++; if (last_done_cyc - start_log[sb+3] !== 64) begin bad++; $display("FAIL to_latency got=%0d want=64", last_done_cyc - start_log[sb+3]); end
        end
        total++; if ({to_cs_n, to_busy} !== 2'b10) begin bad++; $display("FAIL to_cs_busy got=%b want=10", {to_cs_n, to_busy}); end
        exp_frame = 48'h112233445566;
        total++; if (frame_data !== exp_frame) begin bad++; $display("FAIL to_frame_kept got=%h want=%h", frame_data, exp_frame); end
        drop_idx = -1; resp_mul = 16;
        repeat (3) @(negedge clk);
        fv0 = fv_total;
        do_req(1'b0, 7'h3B, 8'h00, c);
        wait_done(400, ok);
        total++; if (fv_total - fv0 !== 1) begin bad++; $display("FAIL to_recover_fv got=%0d want=1", fv_total - fv0); end
        exp_frame = 48'h102030405060;
        total++; if (frame_data !== exp_frame) begin bad++; $display("FAIL to_recover_frame got=%h want=%h", frame_data, exp_frame); end
    endtask

    task automatic test_ignored_start;
        int c, sb, fv0, wd0;
        bit ok;
        logic [8*NR-1:0] exp_frame;
        resp_mul = 17;
        sb = start_log.size(); fv0 = fv_total; wd0 = wd_total;
        do_req(1'b0, 7'h3B, 8'h00, c);
        wait_starts(sb + 2, ok);
        @(posedge clk); #1;
        wr = 1'b1; addr = 7'h11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; wr = 1'b0;
        wait_done(400, ok);
        total++; if (!ok) begin bad++; $display("FAIL ign_wait got=none want=pulse within 400 cycles"); end
        total++; if (fv_total - fv0 !== 1) begin bad++; $display("FAIL ign_fv_count got=%0d want=1", fv_total - fv0); end
        total++; if (start_log.size() - sb !== 7) begin bad++; $display("FAIL ign_byte_count got=%0d want=7", start_log.size() - sb); end
        exp_frame = 48'h112233445566;
        total++; if (frame_data !== exp_frame) begin bad++; $display("FAIL ign_frame got=%h want=%h", frame_data, exp_frame); end
        repeat (40) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_not_queued busy got=%b want=0", busy); end
        total++; if (wd_total - wd0 !== 0) begin bad++; $display("FAIL ign_wr_done got=%0d want=0", wd_total - wd0); end
    endtask

    task automatic test_reset_mid;
        int c, sb, fv0, wd0, to0;
        bit ok;
        sb = start_log.size(); fv0 = fv_total; wd0 = wd_total; to0 = to_total;
        do_req(1'b0, 7'h3B, 8'h00, c);
        wait_starts(sb + 2, ok);
        repeat (3) @(posedge clk);
        #3;
        total++; if (cs_n !== 1'b0) begin bad++; $display("FAIL rmid_pre_cs_n got=%b want=0", cs_n); end
        rst = 1'b1;
        #1;
        total++; if ({cs_n, busy} !== 2'b10) begin bad++; $display("FAIL rmid_async cs_n/busy got=%b want=10", {cs_n, busy}); end
        total++; if (sif.spi_start !== 1'b0) begin bad++; $display("FAIL rmid_spi_start got=%b want=0", sif.spi_start); end
        total++; if (frame_data !== '0) begin bad++; $display("FAIL rmid_frame got=%h want=0", frame_data); end
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        total++; if ((fv_total - fv0) + (wd_total - wd0) + (to_total - to0) !== 0) begin bad++; $display("FAIL rmid_pulses got=%0d want=0", (fv_total - fv0) + (wd_total - wd0) + (to_total - to0)); end
        total++; if ({cs_n, busy} !== 2'b10) begin bad++; $display("FAIL rmid_idle cs_n/busy got=%b want=10", {cs_n, busy}); end
    endtask

    task automatic test_back_to_back;
        int c1, c2, sb2, fv0;
        bit ok;
        logic [8*NR-1:0] exp_frame;
        resp_mul = 17; fv0 = fv_total;
        do_req(1'b0, 7'h3B, 8'h00, c1);
        wait_done(400, ok);
        total++; if (!(ok && frame_valid)) begin bad++; $display("FAIL b2b_first got=%b want=1", ok && frame_valid); end
        total++; if (cs_n !== 1'b1) begin bad++; $display("FAIL b2b_cs_gap got=%b want=1", cs_n); end
        resp_mul = 33;
        sb2 = start_log.size();
        do_req(1'b0, 7'h3B, 8'h00, c2);
        total++; if ({cs_n, busy} !== 2'b01) begin bad++; $display("FAIL b2b_accept cs_n/busy got=%b want=01", {cs_n, busy}); end
        wait_done(400, ok);
        total++; if (fv_total - fv0 !== 2) begin bad++; $display("FAIL b2b_fv_count got=%0d want=2", fv_total - fv0); end
        if (start_log.size() > sb2) begin
            total++; if (start_log[sb2] - c2 !== 5) begin bad++; $display("FAIL b2b_setup got=%0d want=5", start_log[sb2] - c2); end
        end
        exp_frame = 48'h21426384A5C6;
        total++; if (frame_data !== exp_frame) begin bad++; $display("FAIL b2b_frame got=%h want=%h", frame_data, exp_frame); end
    endtask

    initial begin
        test_reset();
        test_burst_read();
        test_write();
        test_timeout();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
